// File: rtl/apb2reg_hs.sv
// apb2reg_hs -- APB3 slave bridge to a request/acknowledge register bus.
//
// An APB access is turned into a register request that stays up until the
// register block acknowledges it or the watchdog expires. The bridge adds
// PREADY wait states and checks address alignment and range. It also returns
// register-side errors and watchdog timeouts as PSLVERR.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   paddr_i         APB address
//   psel_i          APB select
//   penable_i       APB enable
//   pwrite_i        APB write flag
//   pwdata_i        APB write data
//   prdata_o        read data, valid while pready_o is high
//   pready_o        one-cycle transfer completion
//   pslverr_o       transfer error, valid while pready_o is high
//   reg_val_o       register request, held until ack or timeout
//   reg_wr_o        1 = write request
//   reg_adr_o       register word index (paddr >> 2)
//   reg_wr_dat_o    register write data (0 for reads)
//   reg_ack_i       register accepted/completed the request
//   reg_err_i       register error, sampled with reg_ack_i
//   reg_rd_dat_i    register read data, sampled with reg_ack_i
//   timeout_o       one-cycle pulse when the watchdog expires
module apb2reg_hs #(
  parameter int APB_ADDR_WD = 32,
  parameter int APB_DATA_WD = 32,
  parameter int NUMB_REG_WD = 6,
  parameter int TIMEOUT     = 64,
  parameter int TIMEOUT_WD  = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [APB_ADDR_WD-1:0] paddr_i,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [APB_DATA_WD-1:0] pwdata_i,
  output logic [APB_DATA_WD-1:0] prdata_o,
  output logic                   pready_o,
  output logic                   pslverr_o,
  output logic                   reg_val_o,
  output logic                   reg_wr_o,
  output logic [NUMB_REG_WD-1:0] reg_adr_o,
  output logic [APB_DATA_WD-1:0] reg_wr_dat_o,
  input  logic                   reg_ack_i,
  input  logic                   reg_err_i,
  input  logic [APB_DATA_WD-1:0] reg_rd_dat_i,
  output logic                   timeout_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state;
  logic [TIMEOUT_WD-1:0] cnt;
  logic                  setup;
  logic                  addr_legal;
  logic                  cnt_last;

  // A shift is used for the range check so that it stays well formed even
  // when the register index covers every upper address bit.
  assign setup      = psel_i & ~penable_i;
  assign addr_legal = (paddr_i[1:0] == 2'b00) &&
                      ((paddr_i >> (NUMB_REG_WD + 2)) == '0);
  assign cnt_last   = (cnt == TIMEOUT_WD'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      prdata_o     <= '0;
      pready_o     <= 1'b0;
      pslverr_o    <= 1'b0;
      reg_val_o    <= 1'b0;
      reg_wr_o     <= 1'b0;
      reg_adr_o    <= '0;
      reg_wr_dat_o <= '0;
      timeout_o    <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          pready_o  <= 1'b0;
          pslverr_o <= 1'b0;
          prdata_o  <= '0;
          if (setup) begin
            if (addr_legal) begin
              state        <= ST_REQ;
              cnt          <= '0;
              reg_val_o    <= 1'b1;
              reg_wr_o     <= pwrite_i;
              reg_adr_o    <= paddr_i[NUMB_REG_WD+1:2];
              reg_wr_dat_o <= pwrite_i ? pwdata_i : '0;
            end else begin
              // Illegal address: answer at once with an error, no request.
              state     <= ST_RESP;
              pready_o  <= 1'b1;
              pslverr_o <= 1'b1;
            end
          end
        end

        ST_REQ: begin
          // The request runs to ack or timeout even if psel_i drops meanwhile.
          // An ack in the last watchdog cycle takes priority over the timeout.
          if (reg_ack_i) begin
            state     <= ST_RESP;
            reg_val_o <= 1'b0;
            pready_o  <= 1'b1;
            pslverr_o <= reg_err_i;
            prdata_o  <= (!reg_wr_o && !reg_err_i) ? reg_rd_dat_i : '0;
          end else if (cnt_last) begin
            state     <= ST_RESP;
            reg_val_o <= 1'b0;
            pready_o  <= 1'b1;
            pslverr_o <= 1'b1;
            prdata_o  <= '0;
            timeout_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RESP: begin
          state     <= ST_IDLE;
          pready_o  <= 1'b0;
          pslverr_o <= 1'b0;
          prdata_o  <= '0;
        end

        default: begin
          state     <= ST_IDLE;
          pready_o  <= 1'b0;
          pslverr_o <= 1'b0;
          prdata_o  <= '0;
          reg_val_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
